// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types and line levels for the XOR parity link
// Purpose: receiver FSM state type, serial line levels and the parity check
// helper, shared by the receiver and the matching transmitter.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // The running XOR over data and parity bit must equal the selected sense.
  function automatic logic par_ok(input logic acc, input logic odd);
    return acc == odd;
  endfunction

endpackage

// File: rtl/parity_acc.sv
// rtl/parity_acc.sv - clocked running-XOR accumulator
// Purpose: accumulates the XOR of serial bits; shared by the receiver and the
// matching transmitter.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         force the accumulator to 0 (wins over en)
//   en          XOR bit_in into the accumulator
//   bit_in      serial bit
//   acc         current accumulated XOR
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ bit_in;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial parity frame receiver with valid/ready output
// Purpose: reassembles start / DATA_W data bits (LSB first) / parity / stop
// frames, checks parity and framing, and holds the result in a single-entry
// output register.
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   bit_valid, bit_in       line sample strobe and sample
//   out_data, out_valid     received word and its valid flag
//   out_ready               consumer accepts the presented word
//   parity_err, frame_err   error flags of the presented word
//   overrun                 sticky: a frame was dropped while the output was full
//   busy                    a frame is in progress
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t         state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift_q;
  logic              acc;
  logic              acc_clr, acc_en, data_en, stop_smp;

  parity_acc u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (acc_clr),
    .en     (acc_en),
    .bit_in (bit_in),
    .acc    (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every control strobe is qualified by bit_valid so idle cycles hold state.
  always_comb begin
    state_next = state;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    data_en    = 1'b0;
    stop_smp   = 1'b0;
    if (bit_valid) begin
      case (state)
        IDLE: begin
          if (bit_in != IDLE_LVL) begin
            state_next = DATA;
            acc_clr    = 1'b1;
          end
        end
        DATA: begin
          data_en = 1'b1;
          acc_en  = 1'b1;
          if (cnt == LAST_BIT) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          acc_en     = 1'b1;
          state_next = STOP;
        end
        STOP: begin
          stop_smp   = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Bit counter and positional shift: each data bit lands at index cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      shift_q <= '0;
    end else begin
      if (acc_clr) begin
        cnt <= '0;
      end else if (data_en) begin
        cnt <= cnt + 1'b1;
      end
      for (int i = 0; i < DATA_W; i++) begin
        if (data_en && (cnt == i[CNT_W-1:0])) begin
          shift_q[i] <= bit_in;
        end
      end
    end
  end

  // Single-entry output register; a word accepted on the same edge as a new
  // stop sample is replaced without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (stop_smp) begin
      if (!out_valid || out_ready) begin
        out_data   <= shift_q;
        parity_err <= ~par_ok(acc, ODD_PARITY);
        frame_err  <= (bit_in != STOP_LVL);
        out_valid  <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb/tb_parity_frame_rx.sv - randomized self-checking bench for parity_frame_rx
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n, bit_valid, bit_in, out_ready;
  logic [7:0] e_data, o_data;
  logic       e_valid, e_perr, e_ferr, e_ovr, e_busy;
  logic       o_valid, o_perr, o_ferr, o_ovr, o_busy;

  always #5 clk = ~clk;

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .out_data(e_data), .out_valid(e_valid), .out_ready(out_ready),
    .parity_err(e_perr), .frame_err(e_ferr), .overrun(e_ovr), .busy(e_busy)
  );

  parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .out_data(o_data), .out_valid(o_valid), .out_ready(out_ready),
    .parity_err(o_perr), .frame_err(o_ferr), .overrun(o_ovr), .busy(o_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: one held word, its flags for both parity senses.
  logic [7:0] m_data;
  logic       m_valid, m_perr_e, m_perr_o, m_ferr, m_ovr, m_busy;
  logic [7:0] cur_d;
  logic       cur_p, cur_s;

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_perr_e = 1'b0; m_perr_o = 1'b0;
    m_ferr = 1'b0;  m_ovr = 1'b0;   m_busy = 1'b0;
  endtask

  task automatic compare_all();
    check("valid_e", e_valid, m_valid);
    check("valid_o", o_valid, m_valid);
    check("overrun_e", e_ovr, m_ovr);
    check("overrun_o", o_ovr, m_ovr);
    check("busy_e", e_busy, m_busy);
    check("busy_o", o_busy, m_busy);
    if (m_valid) begin
      check("data_e", e_data, m_data);
      check("data_o", o_data, m_data);
      check("perr_e", e_perr, m_perr_e);
      check("perr_o", o_perr, m_perr_o);
      check("ferr_e", e_ferr, m_ferr);
      check("ferr_o", o_ferr, m_ferr);
    end
  endtask

  // role: 0 = no frame event, 1 = start bit, 2 = data/parity, 3 = stop bit
  task automatic tick(input logic bv, input logic b, input logic rdy, input int role);
    logic par;
    bit_valid = bv;
    bit_in    = b;
    out_ready = rdy;
    @(posedge clk);
    if (bv && role == 3) begin
      m_busy = 1'b0;
      if (!m_valid || rdy) begin
        par      = (^cur_d) ^ cur_p;
        m_data   = cur_d;
        m_perr_e = (par != 1'b0);
        m_perr_o = (par != 1'b1);
        m_ferr   = ~cur_s;
        m_valid  = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      if (bv && role == 1) m_busy = 1'b1;
      if (m_valid && rdy) m_valid = 1'b0;
    end
    #1;
    compare_all();
  endtask

  function automatic logic pick_rdy(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return logic'($urandom_range(0, 1));
  endfunction

  // gap_mode: 0 contiguous, 1 alternate idle cycles, 2 random idle cycles
  // rdy_mode: 0 never ready, 1 always ready, 2 random
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int gap_mode, input int rdy_mode);
    logic [10:0] bits;
    int role;
    cur_d = d; cur_p = p; cur_s = s;
    bits  = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (gap_mode == 1 && i > 0) begin
        tick(1'b0, logic'($urandom_range(0, 1)), pick_rdy(rdy_mode), 0);
      end else if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
        tick(1'b0, logic'($urandom_range(0, 1)), pick_rdy(rdy_mode), 0);
      end
      role = (i == 0) ? 1 : ((i == 10) ? 3 : 2);
      tick(1'b1, bits[i], pick_rdy(rdy_mode), role);
    end
  endtask

  task automatic drain();
    tick(1'b0, 1'b1, 1'b1, 0);
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b1; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_data", e_data, 32'h0);
    check("rst_perr", e_perr, 32'h0);
    check("rst_ferr", e_ferr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // clean even-parity frame
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
    check("a5_data", e_data, 32'hA5);
    check("a5_valid", e_valid, 32'h1);
    check("a5_perr", e_perr, 32'h0);
    check("a5_ferr", e_ferr, 32'h0);
    drain();

    // wrong parity for even sense, correct for odd sense
    send_frame(8'h07, 1'b0, 1'b1, 0, 0);
    check("p07_perr_even", e_perr, 32'h1);
    check("p07_perr_odd", o_perr, 32'h0);
    check("p07_data", e_data, 32'h07);
    drain();

    // bad stop bit, then a clean frame
    send_frame(8'h3C, 1'b0, 1'b0, 0, 0);
    check("f3c_ferr", e_ferr, 32'h1);
    check("f3c_perr", e_perr, 32'h0);
    drain();
    send_frame(8'h11, 1'b0, 1'b1, 0, 0);
    check("f11_data", e_data, 32'h11);
    check("f11_ferr", e_ferr, 32'h0);
    drain();

    // overrun: second frame dropped while first is held
    send_frame(8'h01, 1'b1, 1'b1, 0, 0);
    send_frame(8'h02, 1'b1, 1'b1, 0, 0);
    check("ovr_data", e_data, 32'h01);
    check("ovr_flag", e_ovr, 32'h1);
    drain();
    check("ovr_drained", e_valid, 32'h0);

    // sparse bit_valid
    send_frame(8'h5A, 1'b0, 1'b1, 1, 0);
    check("s5a_data", e_data, 32'h5A);
    drain();

    // reset mid-frame with a word held
    send_frame(8'h33, 1'b0, 1'b1, 0, 0);
    cur_d = 8'hC3;
    tick(1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 4; i++) tick(1'b1, logic'($urandom_range(0, 1)), 1'b0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("mid_rst_data", e_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'hFF, 1'b0, 1'b1, 0, 0);
    check("ff_data", e_data, 32'hFF);
    check("ff_perr", e_perr, 32'h0);
    check("ff_ferr", e_ferr, 32'h0);
    drain();

    // back-to-back with ready held high: no bubble, no overrun
    send_frame(8'h81, 1'b0, 1'b1, 0, 1);
    send_frame(8'h7E, 1'b0, 1'b1, 0, 1);
    drain();

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      d = 8'($urandom);
      send_frame(d, (^d) ^ ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), 2, 2);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        tick(logic'($urandom_range(0, 1)), 1'b1, logic'($urandom_range(0, 1)), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
